// File: rtl/misc_st_rr_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : misc_st_rr_arb_if                                             |
// | Purpose  : Bundles the requester-side and DUT-side beat handshakes of    |
// |            the misc_st round-robin arbiter.                              |
// | Signals  : req_valid/req_ready/req_data/req_last - NUM_REQ requester     |
// |            lanes; req_data packs lane i at [i*DATA_W +: DATA_W].         |
// |            out_valid/out_ready/out_data/out_last/out_src - single        |
// |            arbitrated beat stream toward the DUT ingress.                |
// | Modports : slave  - the arbiter (consumes requests, drives out_*).       |
// |            master - the environment (drives requests, sinks out_*).      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface misc_st_rr_arb_if #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_last;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W-1:0]         out_data;
   logic                      out_last;
   logic [SRC_W-1:0]          out_src;

   modport slave (
      input  req_valid, req_data, req_last, out_ready,
      output req_ready, out_valid, out_data, out_last, out_src
   );

   modport master (
      output req_valid, req_data, req_last, out_ready,
      input  req_ready, out_valid, out_data, out_last, out_src
   );
endinterface
`default_nettype wire

// File: rtl/misc_st_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : misc_st_rr_arb                                                |
// | Purpose  : Round-robin packet arbiter sharing the Miscellaneous DUT      |
// |            ingress between NUM_REQ requesters. A grant is held for a     |
// |            whole packet, capped at MAX_BEATS accepted beats.             |
// | Ports    : clk            - rising-edge clock                            |
// |            reset_n        - synchronous active-low reset                 |
// |            arb_en_i       - 1 allows new grants                          |
// |            bus_io         - requester lanes and DUT beat stream          |
// |            gnt_o          - registered one-hot grant                     |
// |            busy_o         - 1 while a packet is granted                  |
// |            err_overlong_o - one-cycle pulse after a forced release       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module misc_st_rr_arb #(
   parameter int NUM_REQ   = 2,
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               arb_en_i,
   misc_st_rr_arb_if.slave    bus_io,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic               busy_o,
   output logic               err_overlong_o
);
   localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = 8;

   localparam logic [0:0]       c_ST_IDLE  = 1'b0;
   localparam logic [0:0]       c_ST_BUSY  = 1'b1;
   localparam logic [SRC_W-1:0] c_LAST_IDX = SRC_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(MAX_BEATS - 1);

   logic [0:0]         state_q, state_d;
   logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0]   gnt_idx_q, gnt_idx_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               err_q, err_d;

   logic [DATA_W-1:0]  w_data_arr [NUM_REQ];
   logic [SRC_W-1:0]   w_cand;
   logic [SRC_W-1:0]   w_win_idx;
   logic               w_win_found;
   logic               w_out_valid;
   logic [DATA_W-1:0]  w_out_data;
   logic               w_out_last;
   logic               w_last_nat;
   logic [SRC_W-1:0]   w_out_src;
   logic [NUM_REQ-1:0] w_req_ready;
   logic               w_beat_acc;

   // Unpack the flat requester data bus so the mux can index by grant.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_data_arr[gi] = bus_io.req_data[gi*DATA_W +: DATA_W];
   end

   // Search from rr_ptr upward with wrap; first valid requester wins.
   always_comb begin
      w_cand      = rr_ptr_q;
      w_win_found = 1'b0;
      w_win_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_win_found && bus_io.req_valid[w_cand]) begin
            w_win_found = 1'b1;
            w_win_idx   = w_cand;
         end
         w_cand = (w_cand == c_LAST_IDX) ? '0 : w_cand + 1'b1;
      end
   end

   // Granted lane is passed straight through; everything is quiet in IDLE.
   always_comb begin
      w_out_valid = 1'b0;
      w_out_data  = '0;
      w_out_last  = 1'b0;
      w_last_nat  = 1'b0;
      w_out_src   = '0;
      w_req_ready = '0;
      if (state_q == c_ST_BUSY) begin
         w_out_valid            = bus_io.req_valid[gnt_idx_q];
         w_out_data             = w_data_arr[gnt_idx_q];
         w_last_nat             = bus_io.req_last[gnt_idx_q];
         w_out_last             = w_last_nat || (beat_cnt_q == c_CNT_MAX);
         w_out_src              = gnt_idx_q;
         w_req_ready[gnt_idx_q] = bus_io.out_ready;
      end
   end

   assign w_beat_acc = (state_q == c_ST_BUSY) && w_out_valid && bus_io.out_ready;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_idx_d  = gnt_idx_q;
      beat_cnt_d = beat_cnt_q;
      gnt_d      = gnt_q;
      err_d      = 1'b0;
      case (state_q)
         c_ST_IDLE: begin
            if (arb_en_i && w_win_found) begin
               state_d    = c_ST_BUSY;
               gnt_idx_d  = w_win_idx;
               gnt_d      = NUM_REQ'(1) << w_win_idx;
               beat_cnt_d = '0;
            end
         end
         c_ST_BUSY: begin
            if (w_beat_acc) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (w_out_last) begin
                  state_d  = c_ST_IDLE;
                  rr_ptr_d = (gnt_idx_q == c_LAST_IDX) ? '0 : gnt_idx_q + 1'b1;
                  gnt_d    = '0;
                  // Only the length cap ended this packet: flag it.
                  err_d    = !w_last_nat;
               end
            end
         end
         default: state_d = c_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= c_ST_IDLE;
         rr_ptr_q   <= '0;
         gnt_idx_q  <= '0;
         beat_cnt_q <= '0;
         gnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_idx_q  <= gnt_idx_d;
         beat_cnt_q <= beat_cnt_d;
         gnt_q      <= gnt_d;
         err_q      <= err_d;
      end
   end

   assign bus_io.out_valid = w_out_valid;
   assign bus_io.out_data  = w_out_data;
   assign bus_io.out_last  = w_out_last;
   assign bus_io.out_src   = w_out_src;
   assign bus_io.req_ready = w_req_ready;

   assign gnt_o          = gnt_q;
   assign busy_o         = (state_q == c_ST_BUSY);
   assign err_overlong_o = err_q;
endmodule
`default_nettype wire

// File: tb/tb_misc_st_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_misc_st_rr_arb                                             |
// | Purpose  : Scoreboard bench for misc_st_rr_arb (NUM_REQ=2, DATA_W=32,    |
// |            MAX_BEATS=16). Requester queues feed the lanes; expected     |
// |            output beats are queued at stimulus time and a monitor       |
// |            pops and compares every accepted beat.                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_misc_st_rr_arb;
   localparam int NUM_REQ   = 2;
   localparam int DATA_W    = 32;
   localparam int MAX_BEATS = 16;
   localparam int SRC_W     = 1;

   typedef struct {
      logic [SRC_W-1:0]  src;
      logic [DATA_W-1:0] data;
      logic              last;
   } exp_t;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_t;

   logic               clk     = 1'b0;
   logic               reset_n = 1'b0;
   logic               arb_en  = 1'b1;
   logic [NUM_REQ-1:0] gnt;
   logic               busy;
   logic               err_overlong;

   int   total    = 0;
   int   bad      = 0;
   int   err_cnt  = 0;
   bit   rdy_mode = 1'b0;

   exp_t  sb [$];
   beat_t rq0 [$];
   beat_t rq1 [$];

   misc_st_rr_arb_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

   misc_st_rr_arb #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .MAX_BEATS (MAX_BEATS)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .arb_en_i       (arb_en),
      .bus_io         (bus.slave),
      .gnt_o          (gnt),
      .busy_o         (busy),
      .err_overlong_o (err_overlong)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Queue n beats on requester r; the first n_exp of them are expected at
   // the output, with out_last forced every MAX_BEATS beats of a chunk.
   task automatic send(input int r, input int n, input logic [DATA_W-1:0] base, input int n_exp);
      int pos = 0;
      for (int k = 0; k < n; k++) begin
         beat_t b;
         exp_t  e;
         b.data = base + DATA_W'(k);
         b.last = (k == n - 1);
         if (r == 0) rq0.push_back(b);
         else        rq1.push_back(b);
         e.src  = SRC_W'(r);
         e.data = b.data;
         e.last = b.last || (pos == MAX_BEATS - 1);
         if (k < n_exp) sb.push_back(e);
         pos = e.last ? 0 : pos + 1;
      end
   endtask

   task automatic wait_done(input string name, input int limit);
      int c = 0;
      while ((sb.size() != 0 || rq0.size() != 0 || rq1.size() != 0) && c < limit) begin
         @(negedge clk);
         c++;
      end
      @(negedge clk);
      chk({"no_timeout_", name}, c < limit, 1'b1);
   endtask

   // Requester lanes: accepts seen before an edge retire the head beat.
   initial begin
      logic [NUM_REQ-1:0] acc;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      forever begin
         @(negedge clk);
         acc = reset_n ? (bus.req_valid & bus.req_ready) : '0;
         @(posedge clk);
         #1;
         if (acc[0] && rq0.size() > 0) rq0.delete(0);
         if (acc[1] && rq1.size() > 0) rq1.delete(0);
         if (rq0.size() > 0) begin
            bus.req_valid[0]          = 1'b1;
            bus.req_data[DATA_W-1:0]  = rq0[0].data;
            bus.req_last[0]           = rq0[0].last;
         end else begin
            bus.req_valid[0] = 1'b0;
            bus.req_last[0]  = 1'b0;
         end
         if (rq1.size() > 0) begin
            bus.req_valid[1]                 = 1'b1;
            bus.req_data[2*DATA_W-1:DATA_W]  = rq1[0].data;
            bus.req_last[1]                  = rq1[0].last;
         end else begin
            bus.req_valid[1] = 1'b0;
            bus.req_last[1]  = 1'b0;
         end
      end
   end

   // DUT-side sink: always ready, or toggling for backpressure.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         bus.out_ready = rdy_mode ? ~bus.out_ready : 1'b1;
      end
   end

   // Monitor: compares every accepted beat against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (err_overlong) err_cnt++;
            if (busy) begin
               if (sb.size() > 0) begin
                  chk("out_src", bus.out_src, sb[0].src);
                  chk("req_ready", bus.req_ready,
                      bus.out_ready ? (2'b01 << sb[0].src) : 2'b00);
               end
            end else begin
               chk("idle_quiet", {bus.out_valid, bus.req_ready}, 3'b000);
            end
            if (bus.out_valid && bus.out_ready) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_beat: got data %0h src %0h, expected no beat",
                           bus.out_data, bus.out_src);
               end else begin
                  e = sb.pop_front();
                  chk("out_data", bus.out_data, e.data);
                  chk("out_last", bus.out_last, e.last);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [12:0]        ov;
      logic [NUM_REQ-1:0] gh [13];
      int                 c;
      int                 e0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err_overlong, 1'b0);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_req_ready", bus.req_ready, 2'b00);
      chk("rst_out_data", bus.out_data, 32'h0);
      reset_n = 1'b1;

      // Both requesters continuously valid, 2-beat packets: 0,1,0,1
      send(0, 2, 32'hA000_0000, 2);
      send(1, 2, 32'hB000_0000, 2);
      send(0, 2, 32'hA100_0000, 2);
      send(1, 2, 32'hB100_0000, 2);
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         ov[k] = bus.out_valid;
         gh[k] = gnt;
      end
      chk("t2_valid_bubbles", ov, 13'h0DB6);
      chk("t2_gnt_pkt0", gh[1], 2'b01);
      chk("t2_gnt_pkt1", gh[4], 2'b10);
      chk("t2_gnt_pkt2", gh[7], 2'b01);
      chk("t2_gnt_pkt3", gh[10], 2'b10);
      wait_done("t2", 50);

      // Single requester 0, 3-beat packet
      send(0, 3, 32'hC000_0000, 3);
      @(negedge clk);
      chk("t1_not_yet_granted", busy, 1'b0);
      @(negedge clk);
      chk("t1_gnt", gnt, 2'b01);
      chk("t1_busy", busy, 1'b1);
      chk("t1_first_valid", bus.out_valid, 1'b1);
      wait_done("t1", 50);
      chk("t1_gnt_released", gnt, 2'b00);
      chk("t1_busy_released", busy, 1'b0);

      // 20-beat packet on requester 1 under backpressure: forced release
      rdy_mode = 1'b1;
      e0 = err_cnt;
      send(1, 20, 32'hD000_0000, 20);
      wait_done("t3", 200);
      chk("t3_err_pulse_cycles", err_cnt - e0, 1);

      // Backpressure on a 4-beat packet, requester 1 waiting behind it
      send(0, 4, 32'hE000_0000, 4);
      send(1, 1, 32'hE100_0000, 1);
      wait_done("t4", 100);
      rdy_mode = 1'b0;

      // arb_en gating
      arb_en = 1'b0;
      send(0, 4, 32'hF000_0000, 4);
      send(1, 2, 32'hF100_0000, 2);
      repeat (4) begin
         @(negedge clk);
         chk("t5_blocked_busy", busy, 1'b0);
         chk("t5_blocked_gnt", gnt, 2'b00);
      end
      arb_en = 1'b1;
      @(negedge clk);
      chk("t5_gnt_on_enable", gnt, 2'b01);
      chk("t5_busy_on_enable", busy, 1'b1);
      arb_en = 1'b0;
      c = 0;
      while (!(sb.size() == 2 && rq0.size() == 0) && c < 50) begin
         @(negedge clk);
         c++;
      end
      chk("no_timeout_t5_pkt", c < 50, 1'b1);
      repeat (4) begin
         @(negedge clk);
         chk("t5_no_regrant_busy", busy, 1'b0);
         chk("t5_no_regrant_gnt", gnt, 2'b00);
      end
      arb_en = 1'b1;
      @(negedge clk);
      chk("t5_gnt_req1", gnt, 2'b10);
      wait_done("t5", 50);

      // Reset during beat 2 of a requester-1 packet (rr_ptr is 1 beforehand)
      send(0, 1, 32'h1100_0000, 1);
      wait_done("t6_pre", 50);
      send(1, 4, 32'h1200_0000, 1);
      c = 0;
      while (sb.size() != 0 && c < 50) begin
         @(posedge clk);
         c++;
      end
      chk("no_timeout_t6_beat1", c < 50, 1'b1);
      #2;
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t6_rst_gnt", gnt, 2'b00);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_err", err_overlong, 1'b0);
      chk("t6_rst_out_valid", bus.out_valid, 1'b0);
      chk("t6_rst_req_ready", bus.req_ready, 2'b00);
      chk("t6_rst_out_data", bus.out_data, 32'h0);
      chk("t6_rst_out_last", bus.out_last, 1'b0);
      chk("t6_rst_out_src", bus.out_src, 1'b0);
      rq1.delete();
      sb.delete();
      send(0, 1, 32'h1300_0000, 1);
      send(1, 1, 32'h1400_0000, 1);
      @(negedge clk);
      reset_n = 1'b1;
      wait_done("t6", 50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
